// File: rtl/mem_multi_port.sv
// Round-robin shared DEPTH x WIDTH memory for NUM_CH valid/ready channels with byte enables and range errors.
// Read data RD_LATENCY cycles after accept, write error one cycle after; ungranted channels see ready low and wait.
module mem_multi_port #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 64,
   parameter int NUM_CH     = 2,
   parameter int RD_LATENCY = 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_CH-1:0]            valid_i,
   output logic [NUM_CH-1:0]            ready_o,
   input  logic [NUM_CH-1:0]            wr_rd_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_CH*WIDTH-1:0]      wdata_i,
   input  logic [NUM_CH*WIDTH/8-1:0]    be_i,
   output logic [NUM_CH-1:0]            rvalid_o,
   output logic [NUM_CH*WIDTH-1:0]      rdata_o,
   output logic [NUM_CH-1:0]            err_o
);
   localparam int NB  = WIDTH / 8;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]      mem [DEPTH];

   logic [CHW-1:0]        ptr;
   logic [CHW-1:0]        gch;
   logic [CHW-1:0]        idx;
   logic                  found;
   logic                  go;
   logic                  in_range;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_wdata;
   logic [NB-1:0]         sel_be;

   logic                  rd_go;
   logic                  rd_err;
   logic [WIDTH-1:0]      rd_dat;
   logic                  wr_err;

   logic                  fin_go;
   logic                  fin_err;
   logic [CHW-1:0]        fin_ch;
   logic [WIDTH-1:0]      fin_dat;

   // first valid channel at or after the pointer, wrapping
   always_comb begin
      found = 1'b0;
      gch   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CHW'((int'(ptr) + i) % NUM_CH);
         if (!found && valid_i[idx]) begin
            found = 1'b1;
            gch   = idx;
         end
      end
   end

   assign go = reset_i && found;

   always_comb begin
      ready_o   = '0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ready_o[c] = go && (gch == CHW'(c));
         if (gch == CHW'(c)) begin
            sel_wr    = wr_rd_i[c];
            sel_addr  = addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = wdata_i[c*WIDTH +: WIDTH];
            sel_be    = be_i[c*NB +: NB];
         end
      end
   end

   assign in_range = 32'(sel_addr) < 32'(DEPTH);
   assign rd_go    = go && !sel_wr;
   assign rd_err   = !in_range;
   assign rd_dat   = in_range ? mem[sel_addr[MW-1:0]] : '0;
   assign wr_err   = go && sel_wr && !in_range;

   always_ff @(posedge clk_i) begin
      if (go && sel_wr && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (sel_be[b]) mem[sel_addr[MW-1:0]][b*8 +: 8] <= sel_wdata[b*8 +: 8];
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         always_ff @(posedge clk_i) begin
            if (!reset_i) begin
               fin_go  <= 1'b0;
               fin_err <= 1'b0;
               fin_ch  <= '0;
               fin_dat <= '0;
            end else begin
               fin_go  <= rd_go;
               fin_err <= rd_err;
               fin_ch  <= gch;
               fin_dat <= rd_dat;
            end
         end
      end else begin : g_lat1
         assign fin_go  = rd_go;
         assign fin_err = rd_err;
         assign fin_ch  = gch;
         assign fin_dat = rd_dat;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ptr      <= '0;
         rvalid_o <= '0;
         rdata_o  <= '0;
         err_o    <= '0;
      end else begin
         if (go) ptr <= (gch == CHW'(NUM_CH - 1)) ? '0 : gch + 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            rvalid_o[c] <= fin_go && (fin_ch == CHW'(c));
            err_o[c]    <= (fin_go && (fin_ch == CHW'(c)) && fin_err) ||
                           (wr_err && (gch == CHW'(c)));
            if (fin_go && (fin_ch == CHW'(c))) rdata_o[c*WIDTH +: WIDTH] <= fin_dat;
         end
      end
   end

endmodule

// File: tb/tb_mem_multi_port.sv
// Randomized and directed bench for mem_multi_port against a transaction-level memory/arbiter model.
module tb_mem_multi_port;
   localparam int WIDTH      = 32;
   localparam int ADDR_WIDTH = 7;
   localparam int DEPTH      = 64;
   localparam int NUM_CH     = 2;
   localparam int RD         = 2;
   localparam int NB         = WIDTH / 8;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_CH-1:0]            valid, ready, wr_rd, rvalid, err;
   logic [NUM_CH*ADDR_WIDTH-1:0] addr;
   logic [NUM_CH*WIDTH-1:0]      wdata, rdata;
   logic [NUM_CH*NB-1:0]         be;

   always #5 clk = ~clk;

   mem_multi_port #(
      .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH),
      .NUM_CH(NUM_CH), .RD_LATENCY(RD)
   ) dut (
      .clk_i(clk), .reset_i(rst_n), .valid_i(valid), .ready_o(ready),
      .wr_rd_i(wr_rd), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // pending request per channel
   bit          pend [NUM_CH];
   bit          p_wr [NUM_CH];
   int          p_addr [NUM_CH];
   logic [31:0] p_dat [NUM_CH];
   logic [3:0]  p_be [NUM_CH];

   // reference model: word array, RR pointer, scheduled output events by cycle slot
   logic [31:0]       mem_m [DEPTH];
   int                m_ptr = 0;
   int                cyc = 0;
   logic [NUM_CH-1:0] ev_rv [4];
   logic [NUM_CH-1:0] ev_err [4];
   logic [31:0]       ev_dat [4][NUM_CH];
   logic [63:0]       held = '0;

   // observations of the DUT for directed checks
   int          acc_cyc [NUM_CH];
   int          rv_cyc [NUM_CH];
   int          err_cyc [NUM_CH];
   logic [31:0] rv_dat [NUM_CH];
   logic        rv_err [NUM_CH];
   int          last_grant;
   int          rv_seq [$];
   logic [31:0] rv_seq_dat [$];

   function automatic logic [31:0] pat(input int a);
      return {8'hA0 ^ 8'(a), 8'h5C, 8'(a), 8'(3 * a)};
   endfunction

   task automatic set_req(input int c, input bit w, input int a, input logic [31:0] d, input logic [3:0] b);
      pend[c] = 1'b1; p_wr[c] = w; p_addr[c] = a; p_dat[c] = d; p_be[c] = b;
   endtask

   task automatic cycle();
      int g;
      int s;
      int ns;
      logic [NUM_CH-1:0] exp_rdy;
      for (int c = 0; c < NUM_CH; c++) begin
         valid[c] = pend[c];
         wr_rd[c] = p_wr[c];
         addr[c*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(p_addr[c]);
         wdata[c*WIDTH +: WIDTH] = p_dat[c];
         be[c*NB +: NB] = p_be[c];
      end
      #3;
      g = -1;
      if (rst_n)
         for (int i = 0; i < NUM_CH; i++)
            if (g < 0 && pend[(m_ptr + i) % NUM_CH]) g = (m_ptr + i) % NUM_CH;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("ready", 64'(ready), 64'(exp_rdy));
      last_grant = -1;
      for (int c = 0; c < NUM_CH; c++) if (ready[c] === 1'b1) last_grant = c;
      s = cyc % 4;
      if (cyc > 0) begin
         for (int c = 0; c < NUM_CH; c++) if (ev_rv[s][c]) held[c*32 +: 32] = ev_dat[s][c];
         check("rvalid", 64'(rvalid), 64'(ev_rv[s]));
         check("err", 64'(err), 64'(ev_err[s]));
         check("rdata", rdata, held);
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (rvalid[c] === 1'b1) begin
            rv_cyc[c] = cyc;
            rv_dat[c] = rdata[c*32 +: 32];
            rv_err[c] = err[c];
            if (c == 0) begin
               rv_seq.push_back(cyc);
               rv_seq_dat.push_back(rdata[31:0]);
            end
         end
         if (err[c] === 1'b1) err_cyc[c] = cyc;
      end
      ev_rv[s] = '0;
      ev_err[s] = '0;
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin ev_rv[k] = '0; ev_err[k] = '0; end
         held = '0;
         m_ptr = 0;
      end else if (g >= 0) begin
         acc_cyc[g] = cyc;
         if (p_wr[g]) begin
            if (p_addr[g] < DEPTH) begin
               for (int b = 0; b < NB; b++)
                  if (p_be[g][b]) mem_m[p_addr[g]][b*8 +: 8] = p_dat[g][b*8 +: 8];
            end else begin
               ev_err[(cyc + 1) % 4][g] = 1'b1;
            end
         end else begin
            ns = (cyc + RD) % 4;
            ev_rv[ns][g]  = 1'b1;
            ev_dat[ns][g] = (p_addr[g] < DEPTH) ? mem_m[p_addr[g]] : 32'h0;
            if (p_addr[g] >= DEPTH) ev_err[ns][g] = 1'b1;
         end
         pend[g] = 1'b0;
         m_ptr = (g + 1) % NUM_CH;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // issue one request, wait (bounded) for its grant, then let the pipeline drain
   task automatic run_req(input int c, input bit w, input int a, input logic [31:0] d, input logic [3:0] b);
      rv_cyc[c] = -1;
      err_cyc[c] = -1;
      set_req(c, w, a, d, b);
      for (int t = 0; t < 20 && pend[c]; t++) cycle();
      if (pend[c]) begin
         check("grant_timeout", 64'(1), 64'(0));
         pend[c] = 1'b0;
      end
      for (int t = 0; t < RD + 2; t++) cycle();
   endtask

   initial begin
      int next_a;
      int gseq [4];
      int gn;
      for (int k = 0; k < 4; k++) begin ev_rv[k] = '0; ev_err[k] = '0; end
      for (int c = 0; c < NUM_CH; c++) begin
         pend[c] = 1'b0; p_wr[c] = 1'b0; p_addr[c] = 0; p_dat[c] = '0; p_be[c] = '0;
         acc_cyc[c] = -1; rv_cyc[c] = -1; err_cyc[c] = -1;
      end
      rst_n = 1'b0;

      // both channels request through reset; afterwards they fill the whole array
      set_req(0, 1'b1, 0, pat(0), 4'hF);
      set_req(1, 1'b1, 1, pat(1), 4'hF);
      cycle();
      cycle();
      rst_n = 1'b1;
      next_a = 2;
      gn = 0;
      for (int t = 0; t < 300 && (pend[0] || pend[1] || next_a < DEPTH); t++) begin
         cycle();
         if (gn < 4) begin gseq[gn] = last_grant; gn++; end
         for (int c = 0; c < NUM_CH; c++)
            if (!pend[c] && next_a < DEPTH) begin
               set_req(c, 1'b1, next_a, pat(next_a), 4'hF);
               next_a++;
            end
      end
      check("fill_done", 64'(pend[0] | pend[1]), 64'(0));
      check("rr_g0", 64'(gseq[0]), 64'(0));
      check("rr_g1", 64'(gseq[1]), 64'(1));
      check("rr_g2", 64'(gseq[2]), 64'(0));
      check("rr_g3", 64'(gseq[3]), 64'(1));
      for (int t = 0; t < 3; t++) cycle();

      // full write then read back
      run_req(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      run_req(0, 1'b0, 5, 32'h0, 4'h0);
      check("t1_data", 64'(rv_dat[0]), 64'(32'hDEADBEEF));
      check("t1_lat", 64'(rv_cyc[0] - acc_cyc[0]), 64'(RD));
      check("t1_err", 64'(rv_err[0]), 64'(0));

      // partial byte write keeps the upper bytes
      run_req(1, 1'b1, 5, 32'h00001122, 4'b0011);
      run_req(1, 1'b0, 5, 32'h0, 4'h0);
      check("t2_data", 64'(rv_dat[1]), 64'(32'hDEAD1122));

      // out-of-range read and write
      run_req(0, 1'b0, DEPTH, 32'h0, 4'h0);
      check("t4_rd_seen", 64'(rv_cyc[0] - acc_cyc[0]), 64'(RD));
      check("t4_rd_err", 64'(rv_err[0]), 64'(1));
      check("t4_rd_data", 64'(rv_dat[0]), 64'(0));
      run_req(0, 1'b1, DEPTH, 32'hFFFFFFFF, 4'hF);
      check("t4_wr_err", 64'(err_cyc[0] - acc_cyc[0]), 64'(1));
      check("t4_wr_novalid", 64'(rv_cyc[0]), 64'(-1));
      run_req(0, 1'b0, 0, 32'h0, 4'h0);
      check("t4_alias_intact", 64'(rv_dat[0]), 64'(pat(0)));

      // back-to-back reads, one per cycle
      rv_seq.delete();
      rv_seq_dat.delete();
      for (int a = 1; a <= 3; a++) begin
         set_req(0, 1'b0, a, 32'h0, 4'h0);
         cycle();
      end
      for (int t = 0; t < RD + 2; t++) cycle();
      check("t5_count", 64'(rv_seq.size()), 64'(3));
      if (rv_seq.size() == 3) begin
         check("t5_gap1", 64'(rv_seq[1] - rv_seq[0]), 64'(1));
         check("t5_gap2", 64'(rv_seq[2] - rv_seq[1]), 64'(1));
         for (int a = 1; a <= 3; a++) check("t5_data", 64'(rv_seq_dat[a-1]), 64'(pat(a)));
      end

      // reset right after a read is accepted
      set_req(0, 1'b0, 7, 32'h0, 4'h0);
      cycle();
      rv_cyc[0] = -1;
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int t = 0; t < RD + 2; t++) cycle();
      check("t6_flushed", 64'(rv_cyc[0]), 64'(-1));
      set_req(0, 1'b0, 8, 32'h0, 4'h0);
      set_req(1, 1'b0, 9, 32'h0, 4'h0);
      cycle();
      check("t6_first_grant", 64'(last_grant), 64'(0));
      for (int t = 0; t < RD + 3; t++) cycle();

      // randomized traffic with withdrawals and occasional reset
      for (int t = 0; t < 600; t++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!pend[c]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(c, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 9)),
                          $urandom, 4'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 15) == 0) begin
               pend[c] = 1'b0;
            end
         end
         rst_n = ($urandom_range(0, 79) != 0);
         cycle();
      end
      rst_n = 1'b1;
      for (int t = 0; t < 8; t++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
